param_regfile: RTL and testbench
================================

# param_regfile

Parametrised architectural register file for the pipelined NAND CPU core. It replaces the single-cycle register file with configurable data width, register count and predicate-flag count. It adds a per-register pending scoreboard, optional writeback-to-read bypass, and a sequenced clear of the storage array after reset or on request. It sits between decode (read and issue side) and writeback (write side).

## Interface
Parameters:
- DATA_W, 16, register data width
- NUM_REGS, 16, number of registers; must be ≥2
- ADDR_W, $clog2(NUM_REGS), register address width (derived)
- NUM_PS, 1, number of predicate-status flags; must be ≥1
- PS_W, (NUM_PS>1 ? $clog2(NUM_PS) : 1), flag select width (derived)
- BYPASS, 1, 1 = same-cycle writeback forwarded to read ports; 0 = no forwarding

Ports:
- clk  in  1  clock, rising edge
- n_rst  in  1  reset; asynchronous assert, active-low
- init_req  in  1  request a storage clear sweep; sampled only when ready=1
- ready  out  1  0 while clearing; reads, issues and writebacks are valid only when 1
- rd_a_addr  in  ADDR_W  read port A address
- rd_a_data  out  DATA_W  read port A data
- rd_a_pending  out  1  register at rd_a_addr awaits writeback
- rd_b_addr  in  ADDR_W  read port B address
- rd_b_data  out  DATA_W  read port B data
- rd_b_pending  out  1  register at rd_b_addr awaits writeback
- ps_sel  in  PS_W  predicate flag read select
- ps_out  out  1  selected predicate flag
- issue_valid  in  1  instruction issued that will write issue_addr
- issue_addr  in  ADDR_W  destination of issued instruction
- issue_hazard  out  1  issue_valid and issue_addr already pending (WAW)
- wb_valid  in  1  writeback valid
- wb_use_rw  in  1  writeback writes a register
- wb_addr  in  ADDR_W  writeback register address
- wb_data  in  DATA_W  writeback data
- wb_write_ps  in  1  writeback writes a predicate flag
- wb_ps_sel  in  PS_W  writeback flag select
- wb_ps  in  1  writeback flag value

## Operation
- Storage: NUM_REGS×DATA_W array with no reset. pending[NUM_REGS] and ps[NUM_PS] are flops reset asynchronously to 0.
- States: CLEAR and READY. n_rst low forces state CLEAR, clear counter = 0, pending = 0, ps = 0.
- CLEAR: each edge writes regs[cnt] = 0 and increments cnt. At the edge where cnt == NUM_REGS-1, the state moves to READY and cnt returns to 0. Issues, writebacks and init_req are ignored (dropped) in CLEAR.
- READY with init_req=1: the next edge enters CLEAR with cnt=0 and clears pending and ps. Any issue or writeback presented in that same cycle is dropped.
- Register write: on wb_valid & wb_use_rw, regs[wb_addr] <= wb_data and pending[wb_addr] <= 0.
- Flag write: on wb_valid & wb_write_ps, ps[wb_ps_sel] <= wb_ps.
- Issue: issue_valid sets pending[issue_addr] <= 1. If the same address is issued and written back in the same cycle, the issue wins and pending stays 1. A writeback to a non-pending register is legal.
- issue_hazard = issue_valid & pending[issue_addr] & ready. It is informational only; the issue is still recorded.
- Reads are combinational. With BYPASS=1, a read whose address matches a valid register writeback returns wb_data and pending=0; the same rule applies to ps_out against the flag writeback. With BYPASS=0, reads return stored state.
- While ready=0: rd_*_data = 0, rd_*_pending = 0, ps_out = 0, issue_hazard = 0.
- Out-of-range addresses (NUM_REGS not a power of two): reads return 0 and pending 0; writes and issues to them are ignored.

## Timing
- Reset values: ready=0, rd_a_data=rd_b_data=0, rd_*_pending=0, ps_out=0, issue_hazard=0.
- After n_rst deasserts, ready rises after exactly NUM_REGS rising edges.
- init_req sampled high in READY: ready falls after 1 edge and stays 0 for NUM_REGS edges.
- Write latency is 1 edge; read latency is 0 cycles (combinational); bypass is visible in the same cycle.
- n_rst asserted mid-sweep restarts the sweep from cnt=0.

## Test plan
- Reset release, NUM_REGS=16 -> ready=0 for 16 edges, then 1; every rd_*_data=0.
- Write 0xBEEF to r5 (ready=1) -> next cycle rd_a_addr=5 returns 0xBEEF; in the same cycle with BYPASS=1 the read returns 0xBEEF, with BYPASS=0 it returns the old value.
- Issue r3, then next cycle rd_b_addr=3 -> rd_b_pending=1; a later writeback of r3 with 0x1234 -> pending=0 and data=0x1234; issue r3 again while pending -> issue_hazard=1.
- Same-cycle issue and writeback to r7 -> r7 data updated and pending[7]=1 afterwards.
- NUM_PS=4: write ps[2]=1 -> ps_sel=2 returns 1, ps_sel=1 returns 0; init_req -> ps all 0 and r5 reads 0 once ready returns after 16 edges.
- Assert n_rst at sweep count 8 -> ready stays 0 for 16 edges after release; writebacks during CLEAR leave the target register at 0.

Source files
------------

// File: rtl/param_regfile_if.sv
// Decode/writeback bundle for the parametrised register file.
// The master side is the pipeline; the slave side is the register file.
interface param_regfile_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_PS   = 1,
  parameter int PS_W     = (NUM_PS > 1) ? $clog2(NUM_PS) : 1
);
  logic              init_req;
  logic              ready;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic              rd_a_pending;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rd_b_data;
  logic              rd_b_pending;
  logic [PS_W-1:0]   ps_sel;
  logic              ps_out;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_hazard;
  logic              wb_valid;
  logic              wb_use_rw;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_write_ps;
  logic [PS_W-1:0]   wb_ps_sel;
  logic              wb_ps;

  modport master (
    output init_req, rd_a_addr, rd_b_addr, ps_sel, issue_valid, issue_addr,
           wb_valid, wb_use_rw, wb_addr, wb_data, wb_write_ps, wb_ps_sel, wb_ps,
    input  ready, rd_a_data, rd_a_pending, rd_b_data, rd_b_pending, ps_out,
           issue_hazard
  );

  modport slave (
    input  init_req, rd_a_addr, rd_b_addr, ps_sel, issue_valid, issue_addr,
           wb_valid, wb_use_rw, wb_addr, wb_data, wb_write_ps, wb_ps_sel, wb_ps,
    output ready, rd_a_data, rd_a_pending, rd_b_data, rd_b_pending, ps_out,
           issue_hazard
  );
endinterface

// File: rtl/param_regfile.sv
// Register file with pending scoreboard, predicate flags, optional writeback
// bypass and a one-register-per-cycle clear sweep after reset or on request.
module param_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_PS   = 1,
  parameter int PS_W     = (NUM_PS > 1) ? $clog2(NUM_PS) : 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          n_rst,
  param_regfile_if.slave rf
);
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              pending_reg [NUM_REGS];
  logic              ps_reg [NUM_PS];

  logic ready, accept;
  logic a_ok, b_ok, iss_ok, wb_ok, sel_ok, wps_ok;
  logic wb_we, ps_we, iss_we;
  logic a_byp, b_byp, ps_byp;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (cnt_reg == LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      READY: begin
        if (rf.init_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign ready  = (state_reg == READY);
  // A sweep request in READY drops every update presented alongside it.
  assign accept = ready & ~rf.init_req;

  // Range checks only matter when the index space is not fully populated.
  generate
    if ((1 << ADDR_W) == NUM_REGS) begin : g_regs_full
      assign a_ok   = 1'b1;
      assign b_ok   = 1'b1;
      assign iss_ok = 1'b1;
      assign wb_ok  = 1'b1;
    end else begin : g_regs_partial
      assign a_ok   = rf.rd_a_addr  < ADDR_W'(NUM_REGS);
      assign b_ok   = rf.rd_b_addr  < ADDR_W'(NUM_REGS);
      assign iss_ok = rf.issue_addr < ADDR_W'(NUM_REGS);
      assign wb_ok  = rf.wb_addr    < ADDR_W'(NUM_REGS);
    end
    if ((1 << PS_W) == NUM_PS) begin : g_ps_full
      assign sel_ok = 1'b1;
      assign wps_ok = 1'b1;
    end else begin : g_ps_partial
      assign sel_ok = rf.ps_sel    < PS_W'(NUM_PS);
      assign wps_ok = rf.wb_ps_sel < PS_W'(NUM_PS);
    end
  endgenerate

  assign wb_we  = accept & rf.wb_valid & rf.wb_use_rw & wb_ok;
  assign ps_we  = accept & rf.wb_valid & rf.wb_write_ps & wps_ok;
  assign iss_we = accept & rf.issue_valid & iss_ok;

  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      regs[cnt_reg] <= '0;
    end else if (wb_we) begin
      regs[rf.wb_addr] <= rf.wb_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
      // Issue takes priority so a same-cycle writeback cannot retire a new producer.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          pending_reg[gi] <= 1'b0;
        end else if (ready && rf.init_req) begin
          pending_reg[gi] <= 1'b0;
        end else if (iss_we && (rf.issue_addr == ADDR_W'(gi))) begin
          pending_reg[gi] <= 1'b1;
        end else if (wb_we && (rf.wb_addr == ADDR_W'(gi))) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
    for (gi = 0; gi < NUM_PS; gi++) begin : g_ps
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          ps_reg[gi] <= 1'b0;
        end else if (ready && rf.init_req) begin
          ps_reg[gi] <= 1'b0;
        end else if (ps_we && (rf.wb_ps_sel == PS_W'(gi))) begin
          ps_reg[gi] <= rf.wb_ps;
        end
      end
    end
  endgenerate

  assign a_byp  = (BYPASS != 0) && wb_we && (rf.wb_addr == rf.rd_a_addr);
  assign b_byp  = (BYPASS != 0) && wb_we && (rf.wb_addr == rf.rd_b_addr);
  assign ps_byp = (BYPASS != 0) && ps_we && (rf.wb_ps_sel == rf.ps_sel);

  always_comb begin
    rf.ready        = ready;
    rf.rd_a_data    = '0;
    rf.rd_a_pending = 1'b0;
    rf.rd_b_data    = '0;
    rf.rd_b_pending = 1'b0;
    rf.ps_out       = 1'b0;
    rf.issue_hazard = 1'b0;
    if (ready) begin
      if (a_ok) begin
        rf.rd_a_data    = a_byp ? rf.wb_data : regs[rf.rd_a_addr];
        rf.rd_a_pending = ~a_byp & pending_reg[rf.rd_a_addr];
      end
      if (b_ok) begin
        rf.rd_b_data    = b_byp ? rf.wb_data : regs[rf.rd_b_addr];
        rf.rd_b_pending = ~b_byp & pending_reg[rf.rd_b_addr];
      end
      if (sel_ok) begin
        rf.ps_out = ps_byp ? rf.wb_ps : ps_reg[rf.ps_sel];
      end
      if (iss_ok) begin
        rf.issue_hazard = rf.issue_valid & pending_reg[rf.issue_addr];
      end
    end
  end
endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile: 16 regs, 4 predicate flags, bypass on.
module tb_param_regfile;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  param_regfile_if #(.DATA_W(16), .NUM_REGS(16), .NUM_PS(4)) rf ();

  param_regfile #(.DATA_W(16), .NUM_REGS(16), .NUM_PS(4), .BYPASS(1)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .rf   (rf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rf.init_req    = 1'b0;
    rf.issue_valid = 1'b0;
    rf.issue_addr  = '0;
    rf.wb_valid    = 1'b0;
    rf.wb_use_rw   = 1'b0;
    rf.wb_addr     = '0;
    rf.wb_data     = '0;
    rf.wb_write_ps = 1'b0;
    rf.wb_ps_sel   = '0;
    rf.wb_ps       = 1'b0;
  endtask

  initial begin
    idle();
    rf.rd_a_addr = '0;
    rf.rd_b_addr = '0;
    rf.ps_sel    = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(rf.ready), 32'd0);
    check("rst_rda", 32'(rf.rd_a_data), 32'd0);
    check("rst_rdb", 32'(rf.rd_b_data), 32'd0);
    check("rst_pend", 32'({rf.rd_a_pending, rf.rd_b_pending}), 32'd0);
    check("rst_ps", 32'(rf.ps_out), 32'd0);
    rf.issue_valid = 1'b1;
    #1;
    check("rst_hazard", 32'(rf.issue_hazard), 32'd0);
    rf.issue_valid = 1'b0;

    // Release: 15 edges still clearing, 16th edge brings ready
    n_rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("sweep_edge%0d", i), 32'(rf.ready), 32'd0);
    end
    tick();
    check("sweep_done", 32'(rf.ready), 32'd1);

    for (int a = 0; a < 16; a++) begin
      rf.rd_a_addr = 4'(a);
      rf.rd_b_addr = 4'(15 - a);
      #1;
      check($sformatf("init_a%0d", a), 32'(rf.rd_a_data), 32'd0);
      check($sformatf("init_b%0d", 15 - a), 32'(rf.rd_b_data), 32'd0);
      tick();
    end

    // Write 0xBEEF to r5, bypass same cycle then stored value
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd5; rf.wb_data = 16'hBEEF;
    rf.rd_a_addr = 4'd5;
    #1;
    check("r5_bypass", 32'(rf.rd_a_data), 32'hBEEF);
    tick();
    idle();
    #1;
    check("r5_stored", 32'(rf.rd_a_data), 32'hBEEF);

    // Scoreboard on r3
    tick();
    rf.issue_valid = 1'b1; rf.issue_addr = 4'd3;
    #1;
    check("r3_hazard_first", 32'(rf.issue_hazard), 32'd0);
    tick();
    rf.issue_valid = 1'b0;
    rf.rd_b_addr = 4'd3;
    #1;
    check("r3_pending", 32'(rf.rd_b_pending), 32'd1);
    rf.issue_valid = 1'b1;
    #1;
    check("r3_hazard_waw", 32'(rf.issue_hazard), 32'd1);
    tick();
    rf.issue_valid = 1'b0;
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd3; rf.wb_data = 16'h1234;
    #1;
    check("r3_byp_pending", 32'(rf.rd_b_pending), 32'd0);
    check("r3_byp_data", 32'(rf.rd_b_data), 32'h1234);
    tick();
    idle();
    #1;
    check("r3_wb_pending", 32'(rf.rd_b_pending), 32'd0);
    check("r3_wb_data", 32'(rf.rd_b_data), 32'h1234);

    // Same-cycle issue and writeback to r7: data lands, pending stays set
    tick();
    rf.issue_valid = 1'b1; rf.issue_addr = 4'd7;
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd7; rf.wb_data = 16'h7777;
    tick();
    idle();
    rf.rd_a_addr = 4'd7;
    #1;
    check("r7_data", 32'(rf.rd_a_data), 32'h7777);
    check("r7_pending", 32'(rf.rd_a_pending), 32'd1);

    // Predicate flag 2
    tick();
    rf.wb_valid = 1'b1; rf.wb_write_ps = 1'b1; rf.wb_ps_sel = 2'd2; rf.wb_ps = 1'b1;
    rf.ps_sel = 2'd2;
    #1;
    check("ps2_bypass", 32'(rf.ps_out), 32'd1);
    tick();
    idle();
    #1;
    check("ps2_stored", 32'(rf.ps_out), 32'd1);
    rf.ps_sel = 2'd1;
    #1;
    check("ps1_clear", 32'(rf.ps_out), 32'd0);

    // init_req with a dropped issue and writeback to r9
    tick();
    rf.ps_sel = 2'd2;
    rf.init_req = 1'b1;
    rf.issue_valid = 1'b1; rf.issue_addr = 4'd9;
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd9; rf.wb_data = 16'h5555;
    tick();
    idle();
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd2; rf.wb_data = 16'hAAAA;
    rf.issue_valid = 1'b1; rf.issue_addr = 4'd2;
    #1;
    check("init_ready_low", 32'(rf.ready), 32'd0);
    check("init_gated_data", 32'(rf.rd_a_data), 32'd0);
    check("init_gated_pend", 32'(rf.rd_a_pending), 32'd0);
    check("init_gated_ps", 32'(rf.ps_out), 32'd0);
    check("init_gated_hazard", 32'(rf.issue_hazard), 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("reinit_edge%0d", i), 32'(rf.ready), 32'd0);
    end
    tick();
    idle();
    #1;
    check("reinit_done", 32'(rf.ready), 32'd1);
    rf.rd_a_addr = 4'd5;
    rf.rd_b_addr = 4'd9;
    #1;
    check("reinit_r5", 32'(rf.rd_a_data), 32'd0);
    check("reinit_r9", 32'(rf.rd_b_data), 32'd0);
    check("reinit_r9_pend", 32'(rf.rd_b_pending), 32'd0);
    check("reinit_ps2", 32'(rf.ps_out), 32'd0);
    rf.rd_a_addr = 4'd7;
    rf.rd_b_addr = 4'd2;
    #1;
    check("reinit_r7_pend", 32'(rf.rd_a_pending), 32'd0);
    check("clear_wb_r2", 32'(rf.rd_b_data), 32'd0);
    check("clear_iss_r2", 32'(rf.rd_b_pending), 32'd0);

    // Reset in the middle of a sweep restarts it
    tick();
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd4; rf.wb_data = 16'h4444;
    tick();
    idle();
    rf.init_req = 1'b1;
    tick();
    rf.init_req = 1'b0;
    rf.wb_valid = 1'b1; rf.wb_use_rw = 1'b1; rf.wb_addr = 4'd12; rf.wb_data = 16'hC0DE;
    for (int i = 0; i < 8; i++) tick();
    n_rst = 1'b0;
    #1;
    check("midrst_ready", 32'(rf.ready), 32'd0);
    tick();
    tick();
    n_rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("resweep_edge%0d", i), 32'(rf.ready), 32'd0);
    end
    tick();
    idle();
    rf.rd_a_addr = 4'd4;
    rf.rd_b_addr = 4'd12;
    #1;
    check("resweep_done", 32'(rf.ready), 32'd1);
    check("resweep_r4", 32'(rf.rd_a_data), 32'd0);
    check("resweep_r12", 32'(rf.rd_b_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
